// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encodings used by uart_tx and uart_rx.
// PARITY_BIT exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int INCLOCK = 40000000;
  localparam int BAUDE   = 921600;
  localparam int UBRR    = INCLOCK / BAUDE;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } tx_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial output of the UART transmitter.
// master drives DIN/wr, slave (the transmitter) drives status and tx.
interface uart_tx_if;
  logic [7:0] DIN;
  logic       wr;
  logic       ready;
  logic       busy;
  logic       done;
  logic       tx;

  modport master (output DIN, output wr, input ready, input busy, input done, input tx);
  modport slave  (input DIN, input wr, output ready, output busy, output done, output tx);
endinterface

// File: rtl/uart_tx_baud.sv
// Per-bit clock counter: counts 0..UBRR-1 and flags the last clock of each bit.
// restart realigns the count to zero on the edge a frame is loaded.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int UBRR_P = UBRR
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int W = cnt_width(UBRR_P);

  logic [W-1:0] cnt;

  assign bit_end = (cnt == W'(UBRR_P - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer; back-to-back frames when refilled in time.
// UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int INCLOCK = uart_pkg::INCLOCK,
  parameter int BAUDE   = uart_pkg::BAUDE
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = INCLOCK / BAUDE;

  tx_state_t  state, state_next;
  logic [7:0] hold_dat;
  logic       hold_valid;
  logic [7:0] shifter;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       load;
  logic       tx_level;
  logic       done_next;
  logic       tx_r;
  logic       done_r;

  uart_tx_baud #(.UBRR_P(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tx_level   = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          load       = 1'b1;
          state_next = START_BIT;
        end
      end
      START_BIT: begin
        tx_level = 1'b0;
        if (bit_end) state_next = DATA_BITS;
      end
      DATA_BITS: begin
        tx_level = shifter[bit_idx];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY_BIT;
`else
          state_next = STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        tx_level = ^shifter;
        if (bit_end) state_next = STOP_BIT;
      end
`endif
      STOP_BIT: begin
        if (bit_end) begin
          done_next = 1'b1;
          if (hold_valid) begin
            load       = 1'b1;
            state_next = START_BIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The load condition requires hold_valid, so it never coincides with an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_dat   <= 8'h00;
    end else if (bus.wr && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_dat   <= bus.DIN;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter <= 8'h00;
      bit_idx <= 3'd0;
    end else if (load) begin
      shifter <= hold_dat;
      bit_idx <= 3'd0;
    end else if (state == DATA_BITS && bit_end) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Line and done are registered one clock behind the state so they stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r   <= 1'b1;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_level;
      done_r <= done_next;
    end
  end

  assign bus.tx    = tx_r;
  assign bus.done  = done_r;
  assign bus.ready = !hold_valid;
  assign bus.busy  = (state != IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter. It is the transmit-side counterpart of the existing uart_rx on the programmer's host link.
- Accepts bytes from the command/flash-readback logic through a one-entry holding buffer.
- Serialises them LSB-first at the fixed baud rate.
- Sends back-to-back frames with no idle gap when the buffer is refilled in time.

Parameters:
- INCLOCK, 40000000, system clock frequency in Hz.
- BAUDE, 921600, line baud rate.
- UBRR (localparam), INCLOCK/BAUDE (integer divide, = 43 at defaults), clocks per bit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- DIN  input  8  byte to transmit; sampled only when wr && ready.
- wr  input  1  write strobe, one clk per byte.
- ready  output  1  holding buffer empty; a wr is accepted only while ready=1.
- busy  output  1  shifter is in any state other than IDLE.
- done  output  1  one-clk pulse at the end of each frame's stop bit.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (async assert, sync-free release): tx=1, ready=1, busy=0, done=0, state=IDLE, bit counter=0, clock counter=0, holding buffer empty. Asserting rst mid-frame drives tx=1 immediately and discards both the frame in flight and the buffered byte.
- Holding buffer: ready = !hold_valid.
  - An edge sampling wr=1 while ready=1 stores DIN and sets hold_valid.
  - wr while ready=0 is ignored; the stored byte is unchanged.
  - On the edge where the shifter takes the buffer, ready is still 0, so a wr on that same edge is ignored.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT (plus PARITY_BIT under the option).
  - IDLE: tx=1. If hold_valid, on the next edge load the shifter from the buffer, clear hold_valid, and enter START_BIT with tx=0.
  - START_BIT: tx=0 for exactly UBRR clocks, then DATA_BITS.
  - DATA_BITS: tx=shifter[bit_idx], bit_idx 0..7, each bit held UBRR clocks. After bit 7, go to STOP_BIT.
  - STOP_BIT: tx=1 for UBRR clocks. On its last clock, assert done for one cycle.
    - If hold_valid, load the next byte and go directly to START_BIT (no idle gap).
    - Otherwise go to IDLE.
- Latency:
  - With the FSM in IDLE, tx falls on the second rising edge after the edge that accepted wr.
  - Frame length is exactly 10*UBRR clocks (430 at defaults).
- Clock counter: 0..UBRR-1, wraps to 0 at each bit boundary. Sized to hold UBRR-1 for any legal parameter set.
- busy=1 from the START_BIT entry edge until the return to IDLE.
- DIN may change freely once accepted.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY_BIT state is inserted between DATA_BITS and STOP_BIT. tx = XOR of the 8 data bits (even parity) for UBRR clocks. Frame becomes 11*UBRR clocks.
- Undefined: the state and its logic are absent and the frame is 8N1.
- The option must match the uart_rx configuration of the same build.

Decomposition:
- Package uart_pkg holds INCLOCK, BAUDE, UBRR and the state encodings; uart_rx and uart_tx share it.
- One natural sub-module: uart_tx_baud, the per-bit clock counter. It outputs bit_end (high when count==UBRR-1) and takes a restart input pulsed on frame load.

Test Plan:
- Reset, then wr with DIN=0x55 → tx: start 0, then 1,0,1,0,1,0,1,0, then stop 1, each level exactly 43 clks; done pulses once at clk 430 after the start edge.
- wr 0xA5, then wr 0x3C as soon as ready returns to 1 → second start bit begins on the clk right after the first stop bit ends, with no idle gap; two done pulses 430 clks apart.
- wr 0x11 accepted, then wr 0x22 while ready=0 → 0x22 dropped; only 0x11 is transmitted; busy falls after its stop bit.
- Assert rst at clk 200 of a frame → tx=1 the same cycle, ready=1, busy=0; next wr 0x81 produces a clean full frame.
- Loopback to uart_rx, send 0x00, 0xFF, 0x5A → DOUT matches each byte and the receiver's clock pulse occurs once per byte.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1 and frame length 473 clks; send 0x03 → parity bit 0.
